riscv_single_top: RTL and testbench

RISCV_SINGLE_TOP -- requirements
Module: riscv_single_top

---
 rtl/riscv_single_top.sv | 379 +++++++++++++++++++++++++++++++++++++
 tb/tb_riscv_single_top.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_single_top.sv
// riscv_single_top: single-cycle RV32I core with combinational imem/dmem reads.
// Define RISCV_SHIFT_INSTR_EN to enable sll/srl/sra/slli/srli/srai.

package riscv_single_pkg;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef enum logic {
    SRC_RS2,
    SRC_IMM
  } alu_src_e;

  typedef enum logic [1:0] {
    RES_ALU,
    RES_MEM,
    RES_PC4
  } res_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4,
    PC_TARGET,
    PC_ALU
  } pc_src_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

endpackage

module riscv_single_rf (
  input  logic        clk,
  input  logic        we3,
  input  logic [4:0]  addr1,
  input  logic [4:0]  addr2,
  input  logic [4:0]  addr3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] _reg [0:31];

  // No reset: architectural registers survive rst.
  always_ff @(posedge clk) begin
    if (we3 && addr3 != 5'd0) begin
      _reg[addr3] <= wd3;
    end
  end

  assign rd1 = (addr1 == 5'd0) ? 32'd0 : _reg[addr1];
  assign rd2 = (addr2 == 5'd0) ? 32'd0 : _reg[addr2];

endmodule

module riscv_single_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  logic [31:0] _mem [0:63];
  logic        unused_addr;

  always_ff @(posedge clk) begin
    if (we) begin
      _mem[addr[7:2]] <= wd;
    end
  end

  assign rd          = _mem[addr[7:2]];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

endmodule

module riscv_single_dp
  import riscv_single_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        rf_we,
  input  imm_src_e    imm_src,
  input  alu_op_e     alu_ctrl,
  input  alu_src_e    alu_src,
  input  res_src_e    res_src,
  input  pc_src_e     pc_src,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] pc,
  output logic [31:0] alu_out,
  output logic [31:0] mem_wd_data
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic [31:0] imm_ext;
  logic [31:0] rs1_val;
  logic [31:0] src_b;
  logic [31:0] alu_y;
  logic [31:0] result;
  logic [4:0]  shamt;
  logic        unused_op;

  riscv_single_rf rf (
    .clk   (clk),
    .we3   (rf_we),
    .addr1 (instr[19:15]),
    .addr2 (instr[24:20]),
    .addr3 (instr[11:7]),
    .wd3   (result),
    .rd1   (rs1_val),
    .rd2   (mem_wd_data)
  );

  always_comb begin
    imm_ext = 32'd0;
    unique case (imm_src)
      IMM_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_ext = {{19{instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm_ext = {{11{instr[31]}}, instr[31], instr[19:12],
                        instr[20], instr[30:21], 1'b0};
      IMM_U: imm_ext = {instr[31:12], 12'd0};
      default: imm_ext = 32'd0;
    endcase
  end

  assign src_b = (alu_src == SRC_IMM) ? imm_ext : mem_wd_data;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_y = 32'd0;
    unique case (alu_ctrl)
      ALU_ADD: alu_y = rs1_val + src_b;
      ALU_SUB: alu_y = rs1_val - src_b;
      ALU_AND: alu_y = rs1_val & src_b;
      ALU_OR:  alu_y = rs1_val | src_b;
      ALU_XOR: alu_y = rs1_val ^ src_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs1_val) < $signed(src_b)};
      ALU_SLL: alu_y = rs1_val << shamt;
      ALU_SRL: alu_y = rs1_val >> shamt;
      ALU_SRA: alu_y = 32'($signed(rs1_val) >>> shamt);
      default: alu_y = 32'd0;
    endcase
  end

  assign alu_out   = alu_y;
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm_ext;

  always_comb begin
    result = alu_y;
    unique case (res_src)
      RES_ALU: result = alu_y;
      RES_MEM: result = mem_rd_data;
      RES_PC4: result = pc_plus4;
      default: result = alu_y;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    unique case (pc_src)
      PC_PLUS4:  pc_d = pc_plus4;
      PC_TARGET: pc_d = pc_target;
      PC_ALU:    pc_d = {alu_y[31:1], 1'b0};
      default:   pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign unused_op = ^instr[6:0];

endmodule

module riscv_single_top
  import riscv_single_pkg::*;
(
  output logic        reg_we,
  output logic        mem_we,
  output imm_src_e    imm_src,
  output alu_op_e     alu_ctrl,
  output alu_src_e    alu_src,
  output res_src_e    res_src,
  output pc_src_e     pc_src,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_wd_data,
  output logic [31:0] pc,
  input  logic        rst,
  input  logic        clk
);

`ifdef RISCV_SHIFT_INSTR_EN
  localparam logic SHIFT_EN = 1'b1;
`else
  localparam logic SHIFT_EN = 1'b0;
`endif

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       alt;
  logic       shift_op;
  logic       alu_ok;
  logic       f7_ok_r;
  logic       f7_ok_i;
  logic       arith_ok;
  logic       r_ok;
  logic       i_ok;
  logic       lw_ok;
  logic       sw_ok;
  logic       br_ok;
  logic       jal_ok;
  logic       jalr_ok;
  logic       zero;
  logic       taken;
  alu_op_e    alu_dec;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  // funct7[5] selects sub/sra; for I-type only srai uses it.
  assign alt      = f7[5] & ((op == OP_R) | (f3 == 3'b101));
  assign shift_op = (f3 == 3'b001) | (f3 == 3'b101);

  always_comb begin
    alu_dec = ALU_ADD;
    alu_ok  = 1'b1;
    unique case (f3)
      3'b000: alu_dec = alt ? ALU_SUB : ALU_ADD;
      3'b001: alu_dec = ALU_SLL;
      3'b010: alu_dec = ALU_SLT;
      3'b011: alu_ok  = 1'b0;
      3'b100: alu_dec = ALU_XOR;
      3'b101: alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_dec = ALU_OR;
      3'b111: alu_dec = ALU_AND;
      default: alu_ok = 1'b0;
    endcase
  end

  assign f7_ok_r = (f7 == 7'h00) |
                   ((f7 == 7'h20) & ((f3 == 3'b000) | (f3 == 3'b101)));
  assign f7_ok_i = (f3 == 3'b001) ? (f7 == 7'h00) :
                   (f3 == 3'b101) ? ((f7 == 7'h00) | (f7 == 7'h20)) :
                   1'b1;

  assign arith_ok = alu_ok & (~shift_op | SHIFT_EN);
  assign r_ok     = (op == OP_R) & f7_ok_r & arith_ok;
  assign i_ok     = (op == OP_I) & f7_ok_i & arith_ok;
  assign lw_ok    = (op == OP_LW) & (f3 == 3'b010);
  assign sw_ok    = (op == OP_SW) & (f3 == 3'b010);
  assign br_ok    = (op == OP_BR) & (f3[2:1] == 2'b00);
  assign jal_ok   = (op == OP_JAL);
  assign jalr_ok  = (op == OP_JALR) & (f3 == 3'b000);

  assign zero  = (alu_out == 32'd0);
  assign taken = f3[0] ? ~zero : zero;

  always_comb begin
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    imm_src  = IMM_I;
    alu_ctrl = ALU_ADD;
    alu_src  = SRC_RS2;
    res_src  = RES_ALU;
    pc_src   = PC_PLUS4;
    unique case (1'b1)
      r_ok: begin
        reg_we   = 1'b1;
        alu_ctrl = alu_dec;
      end
      i_ok: begin
        reg_we   = 1'b1;
        alu_src  = SRC_IMM;
        alu_ctrl = alu_dec;
      end
      lw_ok: begin
        reg_we  = 1'b1;
        alu_src = SRC_IMM;
        res_src = RES_MEM;
      end
      sw_ok: begin
        mem_we  = 1'b1;
        imm_src = IMM_S;
        alu_src = SRC_IMM;
      end
      br_ok: begin
        imm_src  = IMM_B;
        alu_ctrl = ALU_SUB;
        pc_src   = taken ? PC_TARGET : PC_PLUS4;
      end
      jal_ok: begin
        reg_we  = 1'b1;
        imm_src = IMM_J;
        res_src = RES_PC4;
        pc_src  = PC_TARGET;
      end
      jalr_ok: begin
        reg_we  = 1'b1;
        alu_src = SRC_IMM;
        res_src = RES_PC4;
        pc_src  = PC_ALU;
      end
      default: ;
    endcase
  end

  riscv_single_dp dp (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .rf_we       (reg_we & ~rst),
    .imm_src     (imm_src),
    .alu_ctrl    (alu_ctrl),
    .alu_src     (alu_src),
    .res_src     (res_src),
    .pc_src      (pc_src),
    .mem_rd_data (mem_rd_data),
    .pc          (pc),
    .alu_out     (alu_out),
    .mem_wd_data (mem_wd_data)
  );

  riscv_single_mem instr_mem (
    .clk  (clk),
    .we   (1'b0),
    .addr (pc),
    .wd   (32'd0),
    .rd   (instr)
  );

  riscv_single_mem data_mem (
    .clk  (clk),
    .we   (mem_we & ~rst),
    .addr (alu_out),
    .wd   (mem_wd_data),
    .rd   (mem_rd_data)
  );

endmodule

// File: tb/tb_riscv_single_top.sv
// tb_riscv_single_top: ISA-level reference model bench for riscv_single_top.
// Honours RISCV_SHIFT_INSTR_EN the same way the core does.

module tb_riscv_single_top;
  import riscv_single_pkg::*;

`ifdef RISCV_SHIFT_INSTR_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        reg_we;
  logic        mem_we;
  imm_src_e    imm_src;
  alu_op_e     alu_ctrl;
  alu_src_e    alu_src;
  res_src_e    res_src;
  pc_src_e     pc_src;
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wd_data;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_imem [64];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;

  logic        e_rwe, e_mwe, e_alu_chk, e_rd_chk, w_en, s_en;
  logic [31:0] e_alu, e_rd, e_wd, n_pc, w_val, s_val;
  logic [4:0]  w_rd;
  logic [5:0]  s_idx;

  riscv_single_top dut (
    .reg_we      (reg_we),
    .mem_we      (mem_we),
    .imm_src     (imm_src),
    .alu_ctrl    (alu_ctrl),
    .alu_src     (alu_src),
    .res_src     (res_src),
    .pc_src      (pc_src),
    .instr       (instr),
    .alu_out     (alu_out),
    .mem_rd_data (mem_rd_data),
    .mem_wd_data (mem_wd_data),
    .pc          (pc),
    .rst         (rst),
    .clk         (clk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
      logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
      logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2,
      logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2,
      logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rr(logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_reg[r];
  endfunction

  function automatic bit arith_ok(logic [2:0] f3, logic [6:0] f7, bit is_r);
    bit sh = (f3 == 3'd1) || (f3 == 3'd5);
    if (f3 == 3'd3) return 1'b0;
    if (sh && !SHIFT) return 1'b0;
    if (is_r)
      return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (f3 == 3'd1) return f7 == 7'h00;
    if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
    return 1'b1;
  endfunction

  function automatic logic [31:0] arith(logic [2:0] f3, bit alt,
      logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_eval();
    logic [31:0] i, a, b, imm_i, imm_s, imm_b, imm_j, t;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    i     = m_imem[m_pc[7:2]];
    op    = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    a     = rr(i[19:15]);
    b     = rr(i[24:20]);
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    n_pc = m_pc + 32'd4;
    w_en = 0; s_en = 0; e_alu_chk = 0; e_rd_chk = 0;
    w_rd = i[11:7]; w_val = 0; s_idx = 0; s_val = 0;
    e_alu = 0; e_rd = 0; e_wd = b;
    case (op)
      7'h33: if (arith_ok(f3, f7, 1)) begin
        w_en = 1; w_val = arith(f3, f7[5], a, b);
        e_alu_chk = 1; e_alu = w_val;
      end
      7'h13: if (arith_ok(f3, f7, 0)) begin
        w_en = 1; w_val = arith(f3, (f3 == 3'd5) && f7[5], a, imm_i);
        e_alu_chk = 1; e_alu = w_val;
      end
      7'h03: if (f3 == 3'd2) begin
        t = a + imm_i;
        w_en = 1; w_val = m_dmem[t[7:2]];
        e_alu_chk = 1; e_alu = t; e_rd_chk = 1; e_rd = w_val;
      end
      7'h23: if (f3 == 3'd2) begin
        t = a + imm_s;
        s_en = 1; s_idx = t[7:2]; s_val = b;
        e_alu_chk = 1; e_alu = t;
      end
      7'h63: begin
        if (f3 == 3'd0 && a == b) n_pc = m_pc + imm_b;
        if (f3 == 3'd1 && a != b) n_pc = m_pc + imm_b;
      end
      7'h6f: begin
        w_en = 1; w_val = m_pc + 32'd4; n_pc = m_pc + imm_j;
      end
      7'h67: if (f3 == 3'd0) begin
        t = a + imm_i;
        w_en = 1; w_val = m_pc + 32'd4; n_pc = t & ~32'd1;
        e_alu_chk = 1; e_alu = t;
      end
      default: ;
    endcase
    e_rwe = w_en;
    e_mwe = s_en;
  endtask

  task automatic model_commit();
    if (w_en && w_rd != 5'd0) m_reg[w_rd] = w_val;
    if (s_en) m_dmem[s_idx] = s_val;
    m_pc = n_pc;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_arch();
    int bad_r = -1;
    int bad_m = -1;
    for (int k = 0; k < 32; k++)
      if (bad_r < 0 && dut.dp.rf._reg[k] !== m_reg[k]) bad_r = k;
    for (int k = 0; k < 64; k++)
      if (bad_m < 0 && dut.data_mem._mem[k] !== m_dmem[k]) bad_m = k;
    checks += 2;
    if (bad_r >= 0) begin
      errors++;
      $display("FAIL regs x%0d got %h want %h", bad_r,
               dut.dp.rf._reg[bad_r], m_reg[bad_r]);
    end
    if (bad_m >= 0) begin
      errors++;
      $display("FAIL dmem [%0d] got %h want %h", bad_m,
               dut.data_mem._mem[bad_m], m_dmem[bad_m]);
    end
  endtask

  task automatic compare();
    chk("pc", pc, m_pc);
    chk("instr", instr, m_imem[m_pc[7:2]]);
    chk("reg_we", {31'd0, reg_we}, {31'd0, e_rwe});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_mwe});
    chk("mem_wd_data", mem_wd_data, e_wd);
    if (e_alu_chk) chk("alu_out", alu_out, e_alu);
    if (e_rd_chk) chk("mem_rd_data", mem_rd_data, e_rd);
    chk_arch();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_eval();
      compare();
      model_commit();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) m_reg[k] = 32'd0;
    for (int k = 0; k < 64; k++) begin
      m_imem[k] = 32'd0;
      m_dmem[k] = 32'd0;
    end
    m_pc = 32'd0;
  endtask

  // Preload DUT state, then hold rst over one rising edge.
  task automatic start();
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      dut.instr_mem._mem[k] <= m_imem[k];
      dut.data_mem._mem[k]  <= m_dmem[k];
    end
    for (int k = 0; k < 32; k++) dut.dp.rf._reg[k] <= m_reg[k];
    #1;
    rst = 1'b1;
    #1;
    chk("rst_pc", pc, 32'd0);
    m_pc = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr(int pcv);
    int          kind = $urandom_range(0, 9);
    int          tgt  = 4 * $urandom_range(0, 63);
    logic [4:0]  rd   = 5'($urandom_range(0, 7));
    logic [4:0]  rs1  = 5'($urandom_range(0, 7));
    logic [4:0]  rs2  = 5'($urandom_range(0, 7));
    logic [2:0]  f3   = 3'($urandom_range(0, 7));
    logic [6:0]  f7;
    logic [11:0] imm  = 12'($urandom);
    logic [31:0] r    = $urandom;
    if (tgt == pcv) tgt = (pcv + 4) % 256;
    case (kind)
      0, 1: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
             ? 7'h20 : 7'h00;
        if ($urandom_range(0, 15) == 0) f7 = 7'($urandom);
        return enc_r(f7, rs2, rs1, f3, rd, 7'h33);
      end
      2, 3: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      4: return enc_i(12'(4 * $urandom_range(0, 63)), rs1, 3'd2, rd, 7'h03);
      5: return enc_s(12'(4 * $urandom_range(0, 63)), rs2, rs1);
      6: begin
        f3 = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'($urandom_range(0, 1));
        return enc_b(13'(tgt - pcv), rs2, rs1, f3);
      end
      7: return enc_j(21'(tgt - pcv), rd);
      8: return enc_i(12'(tgt + $urandom_range(0, 1)), 5'd0, 3'd0, rd, 7'h67);
      default: begin
        case ($urandom_range(0, 4))
          0: r[6:0] = 7'h37;
          1: r[6:0] = 7'h17;
          2: r[6:0] = 7'h00;
          3: r[6:0] = 7'h73;
          default: r[6:0] = 7'h0f;
        endcase
        return r;
      end
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    rst = 1'b0;

    // Bitwise AND sequence with fixed encodings.
    clear_model();
    m_reg[5] = 32'h01;
    m_reg[6] = 32'hff;
    m_imem[0] = 32'h00627033;
    m_imem[1] = 32'h0062f233;
    m_imem[2] = 32'h00637233;
    start();
    step(1);
    chk("x0_e1", dut.dp.rf._reg[0], 32'd0);
    step(1);
    chk("x4_e2", dut.dp.rf._reg[4], 32'h01);
    step(1);
    chk("x4_e3", dut.dp.rf._reg[4], 32'hff);
    chk("pc_e3", pc, 32'd12);

    // Store then load of -1.
    clear_model();
    m_imem[0] = enc_i(12'hfff, 5'd0, 3'd0, 5'd1, 7'h13);
    m_imem[1] = enc_s(12'd20, 5'd1, 5'd0);
    m_imem[2] = enc_i(12'd20, 5'd0, 3'd2, 5'd2, 7'h03);
    start();
    chk("mwe_c0", {31'd0, mem_we}, 32'd0);
    step(1);
    chk("mwe_c1", {31'd0, mem_we}, 32'd1);
    step(1);
    chk("mwe_c2", {31'd0, mem_we}, 32'd0);
    step(1);
    chk("dmem5", dut.data_mem._mem[5], 32'hffffffff);
    chk("x2_lw", dut.dp.rf._reg[2], 32'hffffffff);

    // beq taken / not taken.
    clear_model();
    m_reg[1] = 32'd5;
    m_reg[2] = 32'd5;
    m_imem[0] = enc_b(13'd8, 5'd2, 5'd1, 3'd0);
    start();
    step(1);
    chk("beq_taken", pc, 32'd8);
    m_reg[2] = 32'd6;
    start();
    step(1);
    chk("beq_fall", pc, 32'd4);

    // jal then jalr back.
    clear_model();
    m_imem[1] = enc_j(21'd16, 5'd1);
    m_imem[5] = enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67);
    start();
    step(2);
    chk("jal_pc", pc, 32'd20);
    chk("jal_x1", dut.dp.rf._reg[1], 32'd8);
    step(1);
    chk("jalr_pc", pc, 32'd8);

    // Asynchronous reset mid-program.
    clear_model();
    m_imem[0] = enc_i(12'd1, 5'd3, 3'd0, 5'd3, 7'h13);
    for (int k = 1; k < 8; k++)
      m_imem[k] = enc_i(12'd1, 5'd4, 3'd0, 5'd4, 7'h13);
    start();
    step(4);
    chk("pc_pre_rst", pc, 32'h10);
    rst = 1'b1;
    #1;
    chk("rst_async", pc, 32'd0);
    m_pc = 32'd0;
    chk_arch();
    @(negedge clk);
    #1;
    chk("rst_hold", pc, 32'd0);
    chk("x3_hold", dut.dp.rf._reg[3], 32'd1);
    chk_arch();
    rst = 1'b0;
    #1;
    step(3);

    // Arithmetic right shift, gated by the shift macro.
    clear_model();
    m_reg[5] = 32'h80000000;
    m_reg[6] = 32'h1234;
    m_reg[7] = 32'd4;
    m_imem[0] = enc_r(7'h20, 5'd7, 5'd5, 3'd5, 5'd6, 7'h33);
    start();
    step(1);
    chk("sra_x6", dut.dp.rf._reg[6], SHIFT ? 32'hf8000000 : 32'h1234);

    // Random programs.
    for (int p = 0; p < 6; p++) begin
      clear_model();
      for (int k = 0; k < 64; k++) begin
        m_imem[k] = rand_instr(4 * k);
        m_dmem[k] = $urandom;
      end
      for (int k = 1; k < 32; k++) m_reg[k] = $urandom;
      m_imem[0] = enc_s(12'(4 * $urandom_range(0, 63)),
                        5'($urandom_range(1, 7)), 5'd0);
      start();
      step(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
